// File: rtl/button_inv_pkg.sv
// Shared types and constants for the button_inv press shaper.
package button_inv_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_PULSE = 2'b01,
    S_WAIT  = 2'b10
  } state_e;

  localparam logic BTN_PRESSED  = 1'b0;
  localparam logic BTN_RELEASED = 1'b1;

  // True only for a clean pressed level; X/Z never counts as a press.
  function automatic logic is_pressed(input logic level);
    if (level == BTN_PRESSED) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/button_inv_sync.sv
// Optional flop chain on the raw button input; flops reset to released (1).
module button_inv_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = clk ^ rst;
      assign dout = din;
    end else begin : g_chain
      logic [SYNC_STAGES-1:0] sync_r;

      // Shift the raw level through the chain; reset loads the released level.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
          sync_r[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
          end
        end
      end

      assign dout = sync_r[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/button_inv.sv
// Active-low push button to single-cycle active-high press pulse.
// Optional debounce filter enabled by defining BUTTON_INV_DEBOUNCE_EN.
module button_inv
  import button_inv_pkg::*;
#(
  parameter int SYNC_STAGES     = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button_push,
  output logic button_pulse
);

  logic   btn_s;
  logic   press_s;
  state_e state_r;
  state_e state_next_s;
  logic   pulse_r;

  button_inv_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (button_push),
    .dout(btn_s)
  );

`ifdef BUTTON_INV_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Count consecutive low samples while idle; the count includes the current sample.
  always_comb begin
    cnt_next_s = CNT_ZERO;
    press_s    = 1'b0;
    if ((state_r == S_INIT) && is_pressed(btn_s)) begin
      if (cnt_r == CNT_MAX) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_next_s = CNT_ZERO;
    end
    if (cnt_next_s == CNT_MAX) begin
      press_s = 1'b1;
    end else begin
      press_s = 1'b0;
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (DEBOUNCE_CYCLES != 0);

  // Without debounce a single clean low sample is a press.
  always_comb begin
    press_s = 1'b0;
    if (is_pressed(btn_s)) begin
      press_s = 1'b1;
    end else begin
      press_s = 1'b0;
    end
  end
`endif

  // Next-state logic; only a clean released level leaves S_WAIT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_INIT: begin
        if (press_s) begin
          state_next_s = S_PULSE;
        end else begin
          state_next_s = S_INIT;
        end
      end
      S_PULSE: begin
        if (is_pressed(btn_s)) begin
          state_next_s = S_WAIT;
        end else begin
          state_next_s = S_INIT;
        end
      end
      S_WAIT: begin
        if (btn_s == BTN_RELEASED) begin
          state_next_s = S_INIT;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      default: begin
        state_next_s = S_INIT;
      end
    endcase
  end

  // State and pulse registers; the pulse flop tracks "state is S_PULSE".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_INIT;
      pulse_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pulse_r <= (state_next_s == S_PULSE);
    end
  end

  assign button_pulse = pulse_r;

endmodule

// File: tb/tb_button_inv.sv
// Randomized and directed bench for button_inv against a press/re-arm model.
module tb_button_inv;
  import button_inv_pkg::*;

`ifdef BUTTON_INV_DEBOUNCE_EN
  localparam int PRESS_RUN = 4;
`else
  localparam int PRESS_RUN = 1;
`endif

  logic clk;
  logic rst;
  logic button_push;
  logic button_pulse;

  int tests_run;
  int tests_failed;

  // Reference model: a pulse fires when a low run reaches PRESS_RUN while armed;
  // any high sample re-arms and restarts the run.
  bit armed;
  int low_run;
  logic exp_pulse;

  button_inv #(
    .SYNC_STAGES    (0),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .button_push (button_push),
    .button_pulse(button_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    armed     = 1'b1;
    low_run   = 0;
    exp_pulse = 1'b0;
  endtask

  task automatic model_sample(input logic b);
    if (b == 1'b1) begin
      armed     = 1'b1;
      low_run   = 0;
      exp_pulse = 1'b0;
    end else begin
      low_run++;
      if (armed && low_run >= PRESS_RUN) begin
        exp_pulse = 1'b1;
        armed     = 1'b0;
      end else begin
        exp_pulse = 1'b0;
      end
    end
  endtask

  // One clock with button level b; rel releases reset on the same drive edge.
  task automatic step(input logic b, input bit rel, input string tag);
    @(negedge clk);
    button_push = b;
    if (rel) rst = 1'b1;
    @(posedge clk);
    model_sample(b);
    #1;
    check_eq(tag, 32'(button_pulse), 32'(exp_pulse));
  endtask

  task automatic run_level(input logic b, input int n, input string tag);
    for (int i = 0; i < n; i++) step(b, 1'b0, tag);
  endtask

  // Assert reset asynchronously, hold it n cycles with a toggling button.
  task automatic hold_reset(input int n, input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq({tag, "_async_pulse"}, 32'(button_pulse), 32'd0);
    check_eq({tag, "_async_state"}, 32'(dut.state_r), 32'(S_INIT));
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      button_push = ~button_push;
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_pulse"}, 32'(button_pulse), 32'd0);
      check_eq({tag, "_hold_state"}, 32'(dut.state_r), 32'(S_INIT));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    button_push  = 1'b1;
    model_reset();

    hold_reset(5, "reset_hold");
    step(1'b1, 1'b1, "rst_release_idle");

    // Single press, held two samples.
    run_level(1'b1, 2, "single_idle");
    run_level(1'b0, 2, "single_press");
    run_level(1'b1, 2, "single_release");

    // Long hold: one pulse, then parked in S_WAIT.
    run_level(1'b0, 10, "long_hold");
    check_eq("long_hold_state", 32'(dut.state_r), 32'(S_WAIT));
    step(1'b1, 1'b0, "long_release");
    check_eq("long_release_state", 32'(dut.state_r), 32'(S_INIT));
    step(1'b1, 1'b0, "long_release2");

    // Repeat press and the fastest 0,1,0 pattern.
    run_level(1'b0, 2, "repeat_a");
    run_level(1'b1, 2, "repeat_gap");
    run_level(1'b0, 2, "repeat_b");
    run_level(1'b1, 1, "repeat_end");
    for (int i = 0; i < 4; i++) step(logic'(i[0]), 1'b0, "fast_repeat");
    run_level(1'b1, 2, "fast_end");

    // Reset while waiting for release, then still held after reset.
    run_level(1'b0, 6, "pre_wait");
    check_eq("pre_wait_state", 32'(dut.state_r), 32'(S_WAIT));
    hold_reset(5, "reset_wait");
    @(negedge clk);
    button_push = 1'b0;
    step(1'b0, 1'b1, "held_after_reset");
    run_level(1'b0, PRESS_RUN + 1, "held_after_reset_more");
    run_level(1'b1, 7, "release7");
    run_level(1'b0, PRESS_RUN + 1, "press_after7");
    run_level(1'b1, 2, "release_after7");

    // Reset while the pulse is high must drop it at once.
    run_level(1'b0, PRESS_RUN, "pre_pulse");
    check_eq("pre_pulse_high", 32'(button_pulse), 32'd1);
    hold_reset(2, "reset_pulse");
    @(negedge clk);
    button_push = 1'b1;
    step(1'b1, 1'b1, "rst_release2");

    // Debounce boundary: one sample short of the threshold, then exactly it.
    run_level(1'b0, 3, "short_low");
    run_level(1'b1, 2, "short_release");
    run_level(1'b0, 4, "exact_low");
    run_level(1'b1, 2, "exact_release");

    // Randomized runs of random length with occasional resets.
    for (int r = 0; r < 200; r++) begin
      if ($urandom_range(0, 39) == 0) begin
        hold_reset(int'($urandom_range(1, 3)), "rand_reset");
        @(negedge clk);
        button_push = logic'($urandom_range(0, 1));
        step(button_push, 1'b1, "rand_rst_release");
      end else begin
        run_level(logic'($urandom_range(0, 1)), int'($urandom_range(1, 6)), "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
